pla_sweep_bist: RTL and testbench

- Built-in self-test engine for the combinational PLA block: drives the PLA's input bus and reads back its output bus.
- Sweeps every input code 0..2^N_IN-1 in ascending order and waits a programmable settle time per vector.
- Captures each response into a packed truth table and compares it against an expected table.
- Reports pass/fail, mismatch count and first failing code. Sits beside the PLA in self-test wrappers and bring-up harnesses.

---
 rtl/pla_sweep_bist.sv | 135 +++++++++++++
 tb/tb_pla_sweep_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_sweep_bist.sv
// Exhaustive sweep self-test for a combinational PLA: steps every input code,
// captures each response into a packed table and counts mismatches.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start, abort     begin a sweep (from IDLE) / stop a running sweep
//   exp_table        expected responses, slice [i*N_OUT +: N_OUT] for code i
//   pla_in, pla_out  drive to / response from the PLA under test
//   busy, done       sweep in progress / one-cycle completion pulse
//   pass             last completed sweep had no mismatches
//   mismatch_cnt     failing codes in the current or last sweep
//   first_fail_idx   lowest failing code, valid when first_fail_vld
//   resp_table       captured responses, same layout as exp_table
module pla_sweep_bist #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_OUT*(1<<N_IN)-1:0]   exp_table,
    output logic [N_IN-1:0]              pla_in,
    input  logic [N_OUT-1:0]             pla_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                mismatch_cnt,
    output logic [N_IN-1:0]              first_fail_idx,
    output logic                         first_fail_vld,
    output logic [N_OUT*(1<<N_IN)-1:0]   resp_table
);

    localparam logic [7:0]      SRELOAD = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST    = N_IN'((1 << N_IN) - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [7:0]      scnt;
    logic [N_OUT-1:0] exp_cur;

    // Expected value for the code currently applied; exp_table is read live.
    always_comb begin
        exp_cur = exp_table[idx*N_OUT +: N_OUT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            scnt           <= '0;
            pla_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            resp_table     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    // abort has priority over a simultaneous start
                    if (start && !abort) begin
                        idx            <= '0;
                        pla_in         <= '0;
                        scnt           <= SRELOAD;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        mismatch_cnt   <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        resp_table     <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (scnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        scnt <= scnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        // partial results are kept; this sample is dropped
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        resp_table[idx*N_OUT +: N_OUT] <= pla_out;
                        if (pla_out != exp_cur) begin
                            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                            if (!first_fail_vld) begin
                                first_fail_idx <= idx;
                                first_fail_vld <= 1'b1;
                            end
                        end
                        if (idx == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx    <= idx + N_IN'(1);
                            pla_in <= idx + N_IN'(1);
                            scnt   <= SRELOAD;
                            state  <= WAIT;
                        end
                    end
                end
                DONE: begin
                    // count already includes the final vector here
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    pass  <= (mismatch_cnt == '0);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_sweep_bist.sv
// Scoreboard bench for pla_sweep_bist: random expected tables and faulty PLA
// modes against a truth-table model, plus control-edge scenarios.
module tb_pla_sweep_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, stuck;
    logic [15:0] exp_table;
    logic [2:0]  pla_in;
    logic [1:0]  pla_out;
    logic        busy, done, pass;
    logic [3:0]  mismatch_cnt;
    logic [2:0]  first_fail_idx;
    logic        first_fail_vld;
    logic [15:0] resp_table;

    logic        start3;
    logic [2:0]  pla_in3;
    logic [1:0]  pla_out3;
    logic        busy3, done3, pass3;
    logic [3:0]  mismatch_cnt3;
    logic [2:0]  first_fail_idx3;
    logic        first_fail_vld3;
    logic [15:0] resp_table3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        pass;
        logic [3:0]  cnt;
        logic [2:0]  ffi;
        logic        ffv;
        logic [15:0] resp;
        int          c0;
        int          settle;
    } exp_t;

    exp_t sb[$];
    int   trace[$];
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        pla_out  = stuck ? 2'b00 : {pla_in[2] & pla_in[1], pla_in[0] | pla_in[2]};
        pla_out3 = {pla_in3[2] & pla_in3[1], pla_in3[0] | pla_in3[2]};
    end

    pla_sweep_bist #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .exp_table(exp_table), .pla_in(pla_in), .pla_out(pla_out),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_vld(first_fail_vld), .resp_table(resp_table)
    );

    pla_sweep_bist #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(1'b0),
        .exp_table(16'hF544), .pla_in(pla_in3), .pla_out(pla_out3),
        .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_cnt(mismatch_cnt3), .first_fail_idx(first_fail_idx3),
        .first_fail_vld(first_fail_vld3), .resp_table(resp_table3)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Truth-table model: evaluate the PLA on every code and diff against et.
    function automatic exp_t model(input logic [15:0] et, input bit stk,
                                   input int c0);
        exp_t e;
        logic [2:0] c;
        logic [1:0] r;
        e.cnt = '0; e.ffi = '0; e.ffv = 1'b0; e.resp = '0;
        e.c0 = c0; e.settle = 1;
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            r = stk ? 2'b00 : {c[2] & c[1], c[0] | c[2]};
            e.resp[2*i +: 2] = r;
            if (r != et[2*i +: 2]) begin
                e.cnt = e.cnt + 4'd1;
                if (!e.ffv) begin
                    e.ffi = c;
                    e.ffv = 1'b1;
                end
            end
        end
        e.pass = (e.cnt == 4'd0);
        return e;
    endfunction

    // Monitor: records the applied code each busy cycle, scores at done.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !prev_busy) trace.delete();
            prev_busy = busy;
            if (busy && !done) trace.push_back(int'(pla_in));
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    bit ok;
                    e = sb.pop_front();
                    check("latency", 32'(cyc - e.c0), 32'(8 * (e.settle + 1)));
                    check("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
                    check("first_fail_vld", 32'(first_fail_vld), 32'(e.ffv));
                    if (e.ffv) check("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
                    check("resp_table", 32'(resp_table), 32'(e.resp));
                    ok = (trace.size() == 8 * (e.settle + 1));
                    for (int k = 0; k < trace.size(); k++)
                        if (trace[k] != k / (e.settle + 1)) ok = 1'b0;
                    check("pla_in_sweep", 32'(ok), 32'd1);
                    @(negedge clk);
                    check("pass", 32'(pass), 32'(e.pass));
                    check("busy_after_done", 32'(busy), 32'd0);
                end
            end
        end else begin
            prev_busy = 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input logic [15:0] et, input bit stk, input string name);
        exp_table = et;
        stuck     = stk;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        sb.push_back(model(et, stk, cyc));
        wait_drain(name);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; stuck = 1'b0;
        start3 = 1'b0; exp_table = 16'hF544;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_tables", {resp_table, 4'(mismatch_cnt), pla_in,
                             first_fail_idx, first_fail_vld}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(16'hF544, 1'b0, "golden");
        run(16'hF540, 1'b0, "single");
        run(16'hF544, 1'b1, "stuck");
        for (int r = 0; r < 8; r++) begin
            logic [15:0] m;
            m = (r % 3 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
            run(16'hF544 ^ m, ($urandom_range(0, 3) == 0), "random");
        end

        // start re-pulsed mid-run must not queue another sweep
        exp_table = 16'hF544; stuck = 1'b0;
        pulse_start();
        sb.push_back(model(16'hF544, 1'b0, cyc));
        repeat (3) @(negedge clk);
        pulse_start();
        wait_drain("restart");
        check("restart_idle_busy", 32'(busy), 32'd0);

        // abort mid-run: no done, pass stays low
        pulse_start();
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // start and abort together in IDLE
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("start_abort_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);

        // reset mid-sweep discards the run
        run(16'hF544, 1'b0, "pre_reset");
        pulse_start();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_flags", {busy, done, pass, first_fail_vld}, 32'd0);
        check("midrst_data", {resp_table, 4'(mismatch_cnt), pla_in,
                              first_fail_idx}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run(16'hF544, 1'b0, "post_reset");

        // longer settle time stretches the sweep
        begin
            int c0, n;
            @(negedge clk) start3 = 1'b1;
            @(negedge clk) start3 = 1'b0;
            c0 = cyc;
            n = 0;
            while (!done3 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("settle3_latency", 32'(cyc - c0), 32'd32);
            @(negedge clk);
            check("settle3_pass", 32'(pass3), 32'd1);
            check("settle3_resp", 32'(resp_table3), 32'hF544);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
